ps2_kbd_rx: RTL and testbench

PS2_KBD_RX -- requirements
Module: ps2_kbd_rx

---
 rtl/ps2_pkg.sv | 29 ++
 rtl/ps2_evt_fifo.sv | 53 +++++
 rtl/ps2_kbd_rx.sv | 164 ++++++++++++++++
 tb/tb_ps2_kbd_rx.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and scan-code constants for the PS/2 keyboard receiver.
package ps2_pkg;

  localparam logic [7:0] CODE_EXT    = 8'hE0;
  localparam logic [7:0] CODE_BRK    = 8'hF0;
  localparam logic [7:0] CODE_LSHIFT = 8'h12;
  localparam logic [7:0] CODE_RSHIFT = 8'h59;
  localparam logic [7:0] CODE_CTRL   = 8'h14;
  localparam logic [7:0] CODE_ALT    = 8'h11;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_evt_t;

  typedef enum logic [1:0] {
    PFX_IDLE    = 2'd0,
    PFX_EXT     = 2'd1,
    PFX_BRK     = 2'd2,
    PFX_EXT_BRK = 2'd3
  } ps2_pfx_e;

  // Odd parity holds when data plus parity carry an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// First-word-fall-through event FIFO; pointers carry one extra wrap bit.
module ps2_evt_fifo import ps2_pkg::*; #(
  parameter int DEPTH = 8,
  parameter int WIDTH = $bits(ps2_evt_t)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             valid,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r, rd_ptr_r, wr_nxt_s, rd_nxt_s;
  logic             valid_r, do_pop_s, do_push_s;

  assign full = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);

  // A pop while empty is ignored; a pop frees room for a push while full.
  always_comb begin
    do_pop_s  = rd_en & valid_r;
    do_push_s = wr_en & (~full | do_pop_s);
    if (do_push_s) wr_nxt_s = wr_ptr_r + 1'b1;
    else           wr_nxt_s = wr_ptr_r;
    if (do_pop_s)  rd_nxt_s = rd_ptr_r + 1'b1;
    else           rd_nxt_s = rd_ptr_r;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
      valid_r  <= 1'b0;
    end else begin
      wr_ptr_r <= wr_nxt_s;
      rd_ptr_r <= rd_nxt_s;
      valid_r  <= (wr_nxt_s != rd_nxt_s);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
  end

  assign rd_data = valid_r ? mem_r[rd_ptr_r[AW-1:0]] : {WIDTH{1'b0}};
  assign valid   = valid_r;

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: frame decode, E0/F0 prefix tracking, modifiers, event FIFO.
// Define PS2_RX_TIMEOUT_EN to add a watchdog that aborts stalled partial frames.
module ps2_kbd_rx import ps2_pkg::*; #(
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic        rd_en,
  output logic        evt_valid,
  output logic [7:0]  evt_code,
  output logic        evt_ext,
  output logic        evt_brk,
  output logic        shift,
  output logic        ctrl,
  output logic        alt,
  output logic        overflow,
  output logic        frame_err,
  output logic [15:0] evt_count
);

  logic [2:0]  clk_sync_r;
  logic [1:0]  data_sync_r;
  logic [3:0]  bit_cnt_r;
  logic [9:0]  shreg_r;
  ps2_pfx_e    pfx_r, pfx_nxt_s;
  ps2_evt_t    evt_s, head_s;
  logic        fall_s, frame_done_s, frame_ok_s, abort_s, evt_gen_s, drop_s;
  logic        fifo_full_s, fifo_valid_s;
  logic        shift_r, ctrl_r, alt_r, overflow_r, frame_err_r;
  logic [15:0] evt_count_r;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clk_sync_r  <= 3'b111;
      data_sync_r <= 2'b11;
    end else begin
      clk_sync_r  <= {clk_sync_r[1:0], ps2_clk};
      data_sync_r <= {data_sync_r[0], ps2_data};
    end
  end

  assign fall_s       = clk_sync_r[2] & ~clk_sync_r[1];
  assign frame_done_s = fall_s && (bit_cnt_r == 4'd10);
  // shreg_r holds start in bit 0, data in 8:1 and parity in bit 9; stop is the live sample.
  assign frame_ok_s   = frame_done_s & ~shreg_r[0] & data_sync_r[1] &
                        odd_parity_ok(shreg_r[8:1], shreg_r[9]);

`ifdef PS2_RX_TIMEOUT_EN
  localparam int              WDW     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WDW-1:0]  WD_LAST = WDW'(TIMEOUT_CYC - 1);
  logic [WDW-1:0] wd_r;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                                       wd_r <= {WDW{1'b0}};
    else if (fall_s || abort_s || bit_cnt_r == 4'd0)   wd_r <= {WDW{1'b0}};
    else                                               wd_r <= wd_r + 1'b1;
  end

  assign abort_s = (bit_cnt_r != 4'd0) && !fall_s && (wd_r == WD_LAST);
`else
  assign abort_s = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bit_cnt_r <= 4'd0;
      shreg_r   <= 10'd0;
    end else if (abort_s) begin
      bit_cnt_r <= 4'd0;
    end else if (fall_s) begin
      if (bit_cnt_r == 4'd10) begin
        bit_cnt_r <= 4'd0;
      end else begin
        bit_cnt_r <= bit_cnt_r + 4'd1;
        shreg_r   <= {data_sync_r[1], shreg_r[9:1]};
      end
    end
  end

  always_comb begin
    pfx_nxt_s  = pfx_r;
    evt_gen_s  = 1'b0;
    evt_s.ext  = (pfx_r == PFX_EXT) || (pfx_r == PFX_EXT_BRK);
    evt_s.brk  = (pfx_r == PFX_BRK) || (pfx_r == PFX_EXT_BRK);
    evt_s.code = shreg_r[8:1];
    if (abort_s || (frame_done_s && !frame_ok_s)) begin
      pfx_nxt_s = PFX_IDLE;
    end else if (frame_ok_s) begin
      if (evt_s.code == CODE_EXT) begin
        case (pfx_r)
          PFX_IDLE: pfx_nxt_s = PFX_EXT;
          PFX_BRK:  pfx_nxt_s = PFX_EXT_BRK;
          default:  pfx_nxt_s = pfx_r;
        endcase
      end else if (evt_s.code == CODE_BRK) begin
        case (pfx_r)
          PFX_IDLE: pfx_nxt_s = PFX_BRK;
          PFX_EXT:  pfx_nxt_s = PFX_EXT_BRK;
          default:  pfx_nxt_s = pfx_r;
        endcase
      end else begin
        evt_gen_s = 1'b1;
        pfx_nxt_s = PFX_IDLE;
      end
    end else begin
      pfx_nxt_s = pfx_r;
    end
  end

  assign drop_s = evt_gen_s & fifo_full_s & ~(rd_en & fifo_valid_s);

  // Modifiers track every decoded event, even one the FIFO has to drop.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pfx_r       <= PFX_IDLE;
      frame_err_r <= 1'b0;
      overflow_r  <= 1'b0;
      evt_count_r <= 16'd0;
      shift_r     <= 1'b0;
      ctrl_r      <= 1'b0;
      alt_r       <= 1'b0;
    end else begin
      pfx_r       <= pfx_nxt_s;
      frame_err_r <= abort_s | (frame_done_s & ~frame_ok_s);
      if (drop_s) overflow_r <= 1'b1;
      if (evt_gen_s && !drop_s) evt_count_r <= evt_count_r + 16'd1;
      if (evt_gen_s) begin
        if (!evt_s.ext && (evt_s.code == CODE_LSHIFT || evt_s.code == CODE_RSHIFT))
          shift_r <= ~evt_s.brk;
        if (evt_s.code == CODE_CTRL) ctrl_r <= ~evt_s.brk;
        if (evt_s.code == CODE_ALT)  alt_r  <= ~evt_s.brk;
      end
    end
  end

  ps2_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(ps2_evt_t))
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .wr_en   (evt_gen_s),
    .wr_data (evt_s),
    .rd_en   (rd_en),
    .rd_data (head_s),
    .valid   (fifo_valid_s),
    .full    (fifo_full_s)
  );

  assign evt_valid = fifo_valid_s;
  assign evt_code  = head_s.code;
  assign evt_ext   = head_s.ext;
  assign evt_brk   = head_s.brk;
  assign shift     = shift_r;
  assign ctrl      = ctrl_r;
  assign alt       = alt_r;
  assign overflow  = overflow_r;
  assign frame_err = frame_err_r;
  assign evt_count = evt_count_r;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Scoreboard bench for ps2_kbd_rx (FIFO_DEPTH=4, TIMEOUT_CYC=100).
`timescale 1ns/1ps
module tb_ps2_kbd_rx;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic        rd_en = 1'b0;
  logic        evt_valid, evt_ext, evt_brk, shift, ctrl, alt, overflow, frame_err;
  logic [7:0]  evt_code;
  logic [15:0] evt_count;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int fe_cnt   = 0;
  bit reading  = 1'b0;
  logic [9:0] sb [$];

  always #5 clk = ~clk;

  ps2_kbd_rx #(.FIFO_DEPTH(4), .TIMEOUT_CYC(100)) dut (
    .clk(clk), .resetn(resetn), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rd_en(rd_en),
    .evt_valid(evt_valid), .evt_code(evt_code), .evt_ext(evt_ext), .evt_brk(evt_brk),
    .shift(shift), .ctrl(ctrl), .alt(alt), .overflow(overflow), .frame_err(frame_err),
    .evt_count(evt_count)
  );

  function automatic logic [10:0] mk_frame(input logic [7:0] code, input bit bad_par, input bit bad_stop);
    logic par;
    par = (~^code) ^ bad_par;
    return {~bad_stop, par, code, 1'b0};
  endfunction

  task automatic send_bit(input logic b);
    ps2_data = b;
    repeat (4) @(posedge clk);
    #1 ps2_clk = 1'b0;
    repeat (8) @(posedge clk);
    #1 ps2_clk = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] code, input bit bad_par, input bit bad_stop);
    logic [10:0] f;
    f = mk_frame(code, bad_par, bad_stop);
    for (int i = 0; i < 11; i++) send_bit(f[i]);
  endtask

  task automatic key(input logic [7:0] code, input bit ext, input bit brk, input bit expect_push);
    if (ext) send_frame(8'hE0, 1'b0, 1'b0);
    if (brk) send_frame(8'hF0, 1'b0, 1'b0);
    if (expect_push) sb.push_back({ext, brk, code});
    send_frame(code, 1'b0, 1'b0);
  endtask

  // Monitor: counts frame_err pulses and, when reading, pops and scores events.
  initial begin
    logic [9:0] exp_evt;
    forever begin
      @(negedge clk);
      if (frame_err) fe_cnt++;
      if (reading) begin
        if (evt_valid && !rd_en) begin
          chk_cnt++;
          if (sb.size() == 0) begin
            $display("FAIL event_unexpected got=%h expected=none", {evt_ext, evt_brk, evt_code});
          end else begin
            exp_evt = sb.pop_front();
            if ({evt_ext, evt_brk, evt_code} !== exp_evt)
              $display("FAIL event got=%h expected=%h", {evt_ext, evt_brk, evt_code}, exp_evt);
            else pass_cnt++;
          end
          rd_en = 1'b1;
        end else begin
          rd_en = 1'b0;
        end
      end
    end
  end

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || evt_valid) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk_cnt++;
    if (n >= 3000) $display("FAIL %s_drain got_remaining=%0d expected=0", name, sb.size());
    else pass_cnt++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    chk_cnt++;
    if ({evt_valid, evt_code, evt_ext, evt_brk} !== 11'd0)
      $display("FAIL reset_head got=%h expected=0", {evt_valid, evt_code, evt_ext, evt_brk});
    else pass_cnt++;
    chk_cnt++;
    if ({shift, ctrl, alt, overflow, frame_err} !== 5'd0)
      $display("FAIL reset_flags got=%b expected=00000", {shift, ctrl, alt, overflow, frame_err});
    else pass_cnt++;
    chk_cnt++;
    if (evt_count !== 16'd0) $display("FAIL reset_count got=%0d expected=0", evt_count);
    else pass_cnt++;
    @(posedge clk);
    #1 resetn = 1'b1;
    repeat (10) @(negedge clk);
    chk_cnt++;
    if (fe_cnt !== 0 || evt_valid !== 1'b0)
      $display("FAIL post_reset_quiet got_fe=%0d got_valid=%b expected=0,0", fe_cnt, evt_valid);
    else pass_cnt++;
  endtask

  task automatic test_break();
    reading = 1'b1;
    key(8'h1C, 1'b0, 1'b0, 1'b1);
    key(8'h1C, 1'b0, 1'b1, 1'b1);
    drain("break");
    chk_cnt++;
    if (evt_count !== 16'd2) $display("FAIL break_count got=%0d expected=2", evt_count);
    else pass_cnt++;
  endtask

  task automatic test_ext();
    key(8'h75, 1'b1, 1'b0, 1'b1);
    key(8'h75, 1'b1, 1'b1, 1'b1);
    key(8'h1C, 1'b0, 1'b0, 1'b1);
    send_frame(8'hE0, 1'b0, 1'b0);
    key(8'h6B, 1'b1, 1'b0, 1'b1);
    drain("ext");
    chk_cnt++;
    if (evt_count !== 16'd6) $display("FAIL ext_count got=%0d expected=6", evt_count);
    else pass_cnt++;
  endtask

  task automatic test_modifiers();
    key(8'h12, 1'b0, 1'b0, 1'b1);
    chk_cnt++;
    if (shift !== 1'b1) $display("FAIL shift_make got=%b expected=1", shift); else pass_cnt++;
    key(8'h1C, 1'b0, 1'b0, 1'b1);
    chk_cnt++;
    if (shift !== 1'b1) $display("FAIL shift_hold got=%b expected=1", shift); else pass_cnt++;
    key(8'h12, 1'b0, 1'b1, 1'b1);
    chk_cnt++;
    if (shift !== 1'b0) $display("FAIL shift_break got=%b expected=0", shift); else pass_cnt++;
    key(8'h59, 1'b0, 1'b0, 1'b1);
    chk_cnt++;
    if (shift !== 1'b1) $display("FAIL rshift_make got=%b expected=1", shift); else pass_cnt++;
    key(8'h59, 1'b0, 1'b1, 1'b1);
    key(8'h12, 1'b1, 1'b0, 1'b1);
    chk_cnt++;
    if (shift !== 1'b0) $display("FAIL shift_ext_ignored got=%b expected=0", shift); else pass_cnt++;
    key(8'h14, 1'b1, 1'b0, 1'b1);
    chk_cnt++;
    if (ctrl !== 1'b1) $display("FAIL ctrl_make got=%b expected=1", ctrl); else pass_cnt++;
    key(8'h14, 1'b0, 1'b1, 1'b1);
    chk_cnt++;
    if (ctrl !== 1'b0) $display("FAIL ctrl_break got=%b expected=0", ctrl); else pass_cnt++;
    key(8'h11, 1'b0, 1'b0, 1'b1);
    chk_cnt++;
    if (alt !== 1'b1) $display("FAIL alt_make got=%b expected=1", alt); else pass_cnt++;
    key(8'h11, 1'b1, 1'b1, 1'b1);
    chk_cnt++;
    if (alt !== 1'b0) $display("FAIL alt_break got=%b expected=0", alt); else pass_cnt++;
    drain("modifiers");
    chk_cnt++;
    if (evt_count !== 16'd16) $display("FAIL mod_count got=%0d expected=16", evt_count);
    else pass_cnt++;
  endtask

  task automatic test_frame_errors();
    int fe0;
    logic [15:0] c0;
    fe0 = fe_cnt;
    c0  = evt_count;
    send_frame(8'h1C, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    chk_cnt++;
    if (fe_cnt !== fe0 + 1) $display("FAIL parity_err_pulse got=%0d expected=%0d", fe_cnt, fe0 + 1);
    else pass_cnt++;
    chk_cnt++;
    if (evt_count !== c0 || evt_valid !== 1'b0)
      $display("FAIL parity_no_push got=%0d expected=%0d", evt_count, c0);
    else pass_cnt++;
    send_frame(8'h29, 1'b0, 1'b1);
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b1, 1'b0);
    key(8'h1C, 1'b0, 1'b0, 1'b1);
    drain("frame_err");
    chk_cnt++;
    if (fe_cnt !== fe0 + 3) $display("FAIL frame_err_total got=%0d expected=%0d", fe_cnt, fe0 + 3);
    else pass_cnt++;
    chk_cnt++;
    if (evt_count !== c0 + 16'd1) $display("FAIL frame_err_count got=%0d expected=%0d", evt_count, c0 + 16'd1);
    else pass_cnt++;
  endtask

  task automatic test_overflow();
    logic [15:0] c0;
    logic [10:0] f;
    logic [9:0]  exp_evt;
    reading = 1'b0;
    c0 = evt_count;
    chk_cnt++;
    if (overflow !== 1'b0) $display("FAIL ovf_initial got=%b expected=0", overflow); else pass_cnt++;
    key(8'h15, 1'b0, 1'b0, 1'b1);
    key(8'h1D, 1'b0, 1'b0, 1'b1);
    key(8'h24, 1'b0, 1'b0, 1'b1);
    key(8'h2D, 1'b0, 1'b0, 1'b1);
    chk_cnt++;
    if (overflow !== 1'b0 || evt_count !== c0 + 16'd4)
      $display("FAIL ovf_full got_ovf=%b got_cnt=%0d expected=0,%0d", overflow, evt_count, c0 + 16'd4);
    else pass_cnt++;
    key(8'h2C, 1'b0, 1'b0, 1'b0);
    chk_cnt++;
    if (overflow !== 1'b1 || evt_count !== c0 + 16'd4 || evt_valid !== 1'b1)
      $display("FAIL ovf_drop got_ovf=%b got_cnt=%0d expected=1,%0d", overflow, evt_count, c0 + 16'd4);
    else pass_cnt++;
    // Sixth frame: pop aligned to the stop-bit push cycle (third clk edge after ps2_clk falls).
    f = mk_frame(8'h4B, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) send_bit(f[i]);
    ps2_data = f[10];
    repeat (4) @(posedge clk);
    #1 ps2_clk = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_evt = sb.pop_front();
    chk_cnt++;
    if ({evt_ext, evt_brk, evt_code} !== exp_evt)
      $display("FAIL ovf_head got=%h expected=%h", {evt_ext, evt_brk, evt_code}, exp_evt);
    else pass_cnt++;
    sb.push_back({2'b00, 8'h4B});
    rd_en = 1'b1;
    @(posedge clk);
    #1 rd_en = 1'b0;
    repeat (7) @(posedge clk);
    #1 ps2_clk = 1'b1;
    repeat (4) @(posedge clk);
    chk_cnt++;
    if (evt_count !== c0 + 16'd5) $display("FAIL ovf_push_pop got=%0d expected=%0d", evt_count, c0 + 16'd5);
    else pass_cnt++;
    reading = 1'b1;
    drain("overflow");
    chk_cnt++;
    if (overflow !== 1'b1) $display("FAIL ovf_sticky got=%b expected=1", overflow); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int fe0;
    logic [10:0] f;
    f = mk_frame(8'h1C, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(f[i]);
    fe0 = fe_cnt;
    @(posedge clk);
    #1 resetn = 1'b0;
    ps2_data = 1'b1;
    repeat (3) @(negedge clk);
    chk_cnt++;
    if ({overflow, shift, evt_valid} !== 3'b000 || evt_count !== 16'd0)
      $display("FAIL mid_reset_clear got=%b,%0d expected=000,0", {overflow, shift, evt_valid}, evt_count);
    else pass_cnt++;
    @(posedge clk);
    #1 resetn = 1'b1;
    repeat (10) @(posedge clk);
    key(8'h3A, 1'b0, 1'b0, 1'b1);
    drain("reset_mid");
    chk_cnt++;
    if (fe_cnt !== fe0 || evt_count !== 16'd1)
      $display("FAIL mid_reset_resume got_fe=%0d got_cnt=%0d expected=%0d,1", fe_cnt, evt_count, fe0);
    else pass_cnt++;
  endtask

  task automatic test_partial_frame();
    int fe0;
    logic [10:0] f;
    f = mk_frame(8'h1C, 1'b0, 1'b0);
`ifdef PS2_RX_TIMEOUT_EN
    begin
      int first;
      first = -1;
      for (int i = 0; i < 3; i++) send_bit(f[i]);
      ps2_data = f[3];
      repeat (4) @(posedge clk);
      #1 ps2_clk = 1'b0;
      fe0 = fe_cnt;
      for (int c = 1; c <= 200; c++) begin
        @(negedge clk);
        if (c == 8) ps2_clk = 1'b1;
        if (frame_err && first < 0) first = c;
      end
      chk_cnt++;
      if (first < 100 || first > 106) $display("FAIL timeout_cycle got=%0d expected=100..106", first);
      else pass_cnt++;
      chk_cnt++;
      if (fe_cnt !== fe0 + 1) $display("FAIL timeout_pulses got=%0d expected=%0d", fe_cnt, fe0 + 1);
      else pass_cnt++;
      key(8'h1C, 1'b0, 1'b0, 1'b1);
    end
`else
    for (int i = 0; i < 4; i++) send_bit(f[i]);
    fe0 = fe_cnt;
    repeat (300) @(negedge clk);
    chk_cnt++;
    if (fe_cnt !== fe0) $display("FAIL partial_no_abort got=%0d expected=%0d", fe_cnt, fe0);
    else pass_cnt++;
    sb.push_back({2'b00, 8'h1C});
    for (int i = 4; i < 11; i++) send_bit(f[i]);
`endif
    drain("partial");
    chk_cnt++;
    if (evt_count !== 16'd2) $display("FAIL partial_count got=%0d expected=2", evt_count);
    else pass_cnt++;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "global timeout");
  end

  initial begin
    test_reset();
    test_break();
    test_ext();
    test_modifiers();
    test_frame_errors();
    test_overflow();
    test_reset_mid();
    test_partial_frame();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
